// File: rtl/reduce_gate_filt.sv
// N-input reduction gate (NOR/NAND/OR/AND) with registered inputs, glitch filter and transition counter.
// Optional feature: define REDUCE_GATE_FILT_STICKY_EN to add the glitch_sticky output.
module reduce_gate_filt #(
    parameter int   NIN      = 2,
    parameter int   FILT_LEN = 4,
    parameter int   CNT_W    = 8,
    parameter logic RST_OUT  = 1'b1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             VDD,
    input  logic             VSS,
    input  logic [NIN-1:0]   in,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             cnt_clr,
`ifdef REDUCE_GATE_FILT_STICKY_EN
    output logic             glitch_sticky,
`endif
    output logic             out,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        MODE_NOR  = 2'b00,
        MODE_NAND = 2'b01,
        MODE_OR   = 2'b10,
        MODE_AND  = 2'b11
    } mode_e;

    logic [NIN-1:0]   in_q;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw;
    logic             toggle;

    // Supply pins carry no logic; folded here so they are visibly consumed.
    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    // Stage 0: capture the asynchronous inputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) in_q <= '0;
        else       in_q <= in;
    end

    // Stage 1: reduction, consecutive-cycle filter, transition counter.
    always_comb begin
        raw = 1'b0;
        case (mode_e'(mode))
            MODE_NOR:  raw = ~|in_q;
            MODE_NAND: raw = ~&in_q;
            MODE_OR:   raw = |in_q;
            MODE_AND:  raw = &in_q;
            default:   raw = 1'b0;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        out_d  = out_q;
        toggle = 1'b0;
        if (!en) begin
            fcnt_d = '0;
        end else if (raw == out_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCNT_LAST) begin
            out_d  = raw;
            fcnt_d = '0;
            toggle = 1'b1;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
    end

    // Clear dominates a coincident toggle; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)                     cnt_d = '0;
        else if (toggle && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fcnt_q <= '0;
            out_q  <= RST_OUT;
            cnt_q  <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef REDUCE_GATE_FILT_STICKY_EN
    logic sticky_q, sticky_d;

    // A rejected glitch (partial count abandoned) sets the flag; set beats clear.
    always_comb begin
        sticky_d = sticky_q;
        if (en && (fcnt_q != '0) && (raw == out_q)) sticky_d = 1'b1;
        else if (cnt_clr)                           sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end

    assign glitch_sticky = sticky_q;
`endif

    assign out        = out_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_reduce_gate_filt.sv
// Scoreboard bench for reduce_gate_filt (NIN=2, FILT_LEN=4, CNT_W=2, RST_OUT=1).
module tb_reduce_gate_filt;

    logic       clk = 1'b0;
    logic       rstb;
    logic [1:0] din;
    logic [1:0] mode;
    logic       en;
    logic       cnt_clr;
    logic       out_w;
    logic [1:0] cnt_w;
`ifdef REDUCE_GATE_FILT_STICKY_EN
    logic       stk_w;
`endif

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic       o;
        logic [1:0] c;
        logic       s;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    reduce_gate_filt #(
        .NIN(2), .FILT_LEN(4), .CNT_W(2), .RST_OUT(1'b1)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .VDD(1'b1),
        .VSS(1'b0),
        .in(din),
        .mode(mode),
        .en(en),
        .cnt_clr(cnt_clr),
`ifdef REDUCE_GATE_FILT_STICKY_EN
        .glitch_sticky(stk_w),
`endif
        .out(out_w),
        .toggle_cnt(cnt_w)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each falling edge, retire every expectation tagged for this cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            n_cmp++;
            if (cur.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: check slot %0d missed, now cycle %0d", cur.name, cur.cyc, cyc);
            end else if ({out_w, cnt_w} !== {cur.o, cur.c}) begin
                n_bad++;
                $display("FAIL %s: out=%b cnt=%0d, expected out=%b cnt=%0d (cycle %0d)",
                         cur.name, out_w, cnt_w, cur.o, cur.c, cyc);
            end
`ifdef REDUCE_GATE_FILT_STICKY_EN
            if (cur.cyc == cyc) begin
                n_cmp++;
                if (stk_w !== cur.s) begin
                    n_bad++;
                    $display("FAIL %s_sticky: got %b, expected %b (cycle %0d)", cur.name, stk_w, cur.s, cyc);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Expectation for the falling edge 'ahead' cycles after the current one.
    task automatic expect_at(input int ahead, input logic o, input logic [1:0] c,
                             input logic s, input string nm);
        exp_t e;
        e.cyc  = cyc + ahead;
        e.o    = o;
        e.c    = c;
        e.s    = s;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        rstb    = 1'b0;
        din     = 2'b00;
        mode    = 2'b00;
        en      = 1'b1;
        cnt_clr = 1'b0;
        tick();

        // Reset and idle with NOR of zeros.
        expect_at(0, 1'b1, 2'd0, 1'b0, "rst_low");
        run(2);
        rstb = 1'b1;
        for (int k = 0; k < 6; k++) expect_at(k, 1'b1, 2'd0, 1'b0, "idle");
        run(6);

        // Input change: out falls FILT_LEN+1 edges later.
        din = 2'b01;
        expect_at(0, 1'b1, 2'd0, 1'b0, "fall_pre0");
        expect_at(4, 1'b1, 2'd0, 1'b0, "fall_pre");
        expect_at(5, 1'b0, 2'd1, 1'b0, "fall");
        run(6);

        // Three-cycle glitch is rejected.
        din = 2'b00;
        expect_at(3, 1'b0, 2'd1, 1'b0, "glitch_mid");
        expect_at(4, 1'b0, 2'd1, 1'b0, "glitch_full");
        expect_at(5, 1'b0, 2'd1, 1'b1, "glitch_rej");
        expect_at(8, 1'b0, 2'd1, 1'b1, "glitch_end");
        run(3);
        din = 2'b01;
        run(6);

        // Enable low for 10 cycles, then a full count after re-enable.
        en  = 1'b0;
        din = 2'b00;
        expect_at(0,  1'b0, 2'd1, 1'b1, "en_off0");
        expect_at(5,  1'b0, 2'd1, 1'b1, "en_off5");
        expect_at(9,  1'b0, 2'd1, 1'b1, "en_off9");
        expect_at(13, 1'b0, 2'd1, 1'b1, "en_pre");
        expect_at(14, 1'b1, 2'd2, 1'b1, "en_upd");
        run(10);
        en = 1'b1;
        run(5);

        // Mode toggles with in=0: saturation, then clear on a toggle edge.
        mode = 2'b10;
        expect_at(3,  1'b1, 2'd2, 1'b1, "sat_pre");
        expect_at(4,  1'b0, 2'd3, 1'b1, "sat_t3");
        expect_at(9,  1'b0, 2'd3, 1'b1, "sat_hold0");
        expect_at(10, 1'b1, 2'd3, 1'b1, "sat_hold");
        expect_at(15, 1'b1, 2'd3, 1'b1, "clr_pre");
        expect_at(16, 1'b0, 2'd0, 1'b0, "clr_tog");
        expect_at(21, 1'b0, 2'd0, 1'b0, "after_clr0");
        expect_at(22, 1'b1, 2'd1, 1'b0, "after_clr");
        run(6);
        mode = 2'b00;
        run(6);
        mode = 2'b10;
        run(3);
        cnt_clr = 1'b1;
        run(1);
        cnt_clr = 1'b0;
        run(2);
        mode = 2'b00;
        run(5);

        // Reset mid-count with out=0 and fcnt=3.
        mode = 2'b10;
        expect_at(3,  1'b1, 2'd1, 1'b0, "rst_pre");
        expect_at(4,  1'b0, 2'd2, 1'b0, "rst_tog");
        expect_at(8,  1'b0, 2'd2, 1'b0, "rst_cnt");
        expect_at(9,  1'b1, 2'd0, 1'b0, "rst_async");
        expect_at(10, 1'b1, 2'd0, 1'b0, "rst_rel");
        expect_at(16, 1'b1, 2'd0, 1'b0, "rst_after");
        run(6);
        mode = 2'b00;
        run(3);
        rstb = 1'b0;
        run(1);
        rstb = 1'b1;
        run(7);

        // AND and NAND modes.
        mode = 2'b11;
        expect_at(3,  1'b1, 2'd0, 1'b0, "and_pre");
        expect_at(4,  1'b0, 2'd1, 1'b0, "and_fall");
        expect_at(10, 1'b0, 2'd1, 1'b0, "and_pre2");
        expect_at(11, 1'b1, 2'd2, 1'b0, "and_rise");
        expect_at(15, 1'b1, 2'd2, 1'b0, "nand_pre");
        expect_at(16, 1'b0, 2'd3, 1'b0, "nand_fall");
        run(6);
        din = 2'b11;
        run(6);
        mode = 2'b01;
        run(5);

        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
